matmul_idx_seq: RTL and testbench

Index sequencer for the matrix-multiply datapath; the consuming end of the loop-address handshake. It owns the current `(i, j, k)` tuple and presents it to the address generator. It steps the tuple using the generator's `adv_i`/`adv_j`/`gen_done` flags and issues one MAC operation per tuple over a valid/ready handshake, with accumulator control and linear operand addresses. It sits between the address generator and the MAC/accumulator unit, and raises `eval_done` when the product is complete.

---
 rtl/matmul_idx_seq.sv | 175 +++++++++++++++++
 tb/tb_matmul_idx_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/matmul_idx_seq.sv
// +----------------------------------------------------------------------------+
// | matmul_idx_seq                                                             |
// | Matrix-multiply index sequencer: steps (i,j,k) from generator flags and    |
// | issues one MAC per tuple over valid/ready.                                 |
// | Optional macro: MATMUL_ADDR_CALC_EN (linear operand/result addresses).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module matmul_idx_seq #(
  parameter int IW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [IW-1:0] num_i,
  input  logic [IW-1:0] num_j,
  input  logic [IW-1:0] num_k,
  input  logic          adv_i,
  input  logic          adv_j,
  input  logic          gen_done,
  output logic [IW-1:0] curr_i,
  output logic [IW-1:0] curr_j,
  output logic [IW-1:0] curr_k,
  output logic          mac_valid,
  input  logic          mac_ready,
  output logic          acc_clear,
  output logic          acc_last,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [AW-1:0] addr_c,
  output logic          busy,
  output logic          eval_done,
  output logic          err_shape
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_ISSUE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [IW-1:0] num_i_q, num_i_d, num_j_q, num_j_d, num_k_q, num_k_d;
  logic [IW-1:0] curr_i_q, curr_i_d, curr_j_q, curr_j_d, curr_k_q, curr_k_d;
  logic          err_q, err_d;

  always_comb begin
    state_d  = state_q;
    num_i_d  = num_i_q;
    num_j_d  = num_j_q;
    num_k_d  = num_k_q;
    curr_i_d = curr_i_q;
    curr_j_d = curr_j_q;
    curr_k_d = curr_k_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_i_d = num_i;
          num_j_d = num_j;
          num_k_d = num_k;
          if ((num_i == '0) || (num_j == '0) || (num_k == '0)) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            err_d    = 1'b0;
            curr_i_d = '0;
            curr_j_d = '0;
            curr_k_d = '0;
            state_d  = S_PRIME;
          end
        end
      end
      // PRIME gives the generator one edge to register flags for the new tuple
      S_PRIME: state_d = S_ISSUE;
      S_ISSUE: begin
        if (mac_ready) begin
          if (gen_done) begin
            state_d = S_FINISH;
          end else if (adv_i) begin
            curr_i_d = curr_i_q + IDX_ONE;
            curr_j_d = '0;
            curr_k_d = '0;
            state_d  = S_PRIME;
          end else if (adv_j) begin
            curr_j_d = curr_j_q + IDX_ONE;
            curr_k_d = '0;
            state_d  = S_PRIME;
          end else begin
            curr_k_d = curr_k_q + IDX_ONE;
            state_d  = S_PRIME;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      num_i_q  <= '0;
      num_j_q  <= '0;
      num_k_q  <= '0;
      curr_i_q <= '0;
      curr_j_q <= '0;
      curr_k_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_i_q  <= num_i_d;
      num_j_q  <= num_j_d;
      num_k_q  <= num_k_d;
      curr_i_q <= curr_i_d;
      curr_j_q <= curr_j_d;
      curr_k_q <= curr_k_d;
      err_q    <= err_d;
    end
  end

  // num_i is kept for completeness but no output depends on it
  logic shape_unused;
  assign shape_unused = ^{num_i_q, num_j_q};

`ifdef MATMUL_ADDR_CALC_EN
  logic [2*IW-1:0] sum_a, sum_b, sum_c;
  logic [AW-1:0]   addr_a_q, addr_b_q, addr_c_q;

  // Addresses are computed from the next tuple so they move on the same edge
  always_comb begin
    sum_a = ({{IW{1'b0}}, curr_i_d} * {{IW{1'b0}}, num_k_d}) + {{IW{1'b0}}, curr_k_d};
    sum_b = ({{IW{1'b0}}, curr_k_d} * {{IW{1'b0}}, num_j_d}) + {{IW{1'b0}}, curr_j_d};
    sum_c = ({{IW{1'b0}}, curr_i_d} * {{IW{1'b0}}, num_j_d}) + {{IW{1'b0}}, curr_j_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
    end else begin
      addr_a_q <= AW'(sum_a);
      addr_b_q <= AW'(sum_b);
      addr_c_q <= AW'(sum_c);
    end
  end

  assign addr_a = addr_a_q;
  assign addr_b = addr_b_q;
  assign addr_c = addr_c_q;
`else
  assign addr_a = '0;
  assign addr_b = '0;
  assign addr_c = '0;
`endif

  assign curr_i    = curr_i_q;
  assign curr_j    = curr_j_q;
  assign curr_k    = curr_k_q;
  assign mac_valid = (state_q == S_ISSUE);
  assign acc_clear = mac_valid && (curr_k_q == '0);
  assign acc_last  = mac_valid && (curr_k_q == (num_k_q - IDX_ONE));
  assign busy      = (state_q != S_IDLE);
  assign eval_done = (state_q == S_FINISH);
  assign err_shape = err_q;

endmodule

`default_nettype wire

// File: tb/tb_matmul_idx_seq.sv
// +----------------------------------------------------------------------------+
// | tb_matmul_idx_seq                                                          |
// | Directed self-checking bench for matmul_idx_seq with a generator model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_matmul_idx_seq;
  localparam int IW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset, start, mac_ready;
  logic [IW-1:0] num_i, num_j, num_k;
  logic          adv_i, adv_j, gen_done;
  logic [IW-1:0] curr_i, curr_j, curr_k;
  logic          mac_valid, acc_clear, acc_last, busy, eval_done, err_shape;
  logic [AW-1:0] addr_a, addr_b, addr_c;

  int n_checks = 0;
  int n_err    = 0;
  int gI = 1, gJ = 1, gK = 1;

  matmul_idx_seq #(.IW(IW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .num_i(num_i), .num_j(num_j), .num_k(num_k),
    .adv_i(adv_i), .adv_j(adv_j), .gen_done(gen_done),
    .curr_i(curr_i), .curr_j(curr_j), .curr_k(curr_k),
    .mac_valid(mac_valid), .mac_ready(mac_ready),
    .acc_clear(acc_clear), .acc_last(acc_last),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
    .busy(busy), .eval_done(eval_done), .err_shape(err_shape)
  );

  always #5 clk = ~clk;

  // Conforming address generator: flags registered from the presented tuple
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      adv_i    <= 1'b0;
      adv_j    <= 1'b0;
      gen_done <= 1'b0;
    end else begin
      adv_j    <= (curr_k == IW'(gK - 1));
      adv_i    <= (curr_k == IW'(gK - 1)) && (curr_j == IW'(gJ - 1));
      gen_done <= (curr_k == IW'(gK - 1)) && (curr_j == IW'(gJ - 1)) && (curr_i == IW'(gI - 1));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] eaddr(input int x, input int n, input int y);
`ifdef MATMUL_ADDR_CALC_EN
    return 64'(x * n + y);
`else
    return 64'(0 * (x + n + y));
`endif
  endfunction

  // One run: S stall cycles per ISSUE, optional ignored start, optional abort at (1,0,2)
  task automatic run(input int I, input int J, input int K, input int S,
                     input bit inject, input bit abort);
    int ei = 0, ej = 0, ek = 0, cyc, stall = 0, issues = 0, done_cyc = -1;
    bit fin = 0;
    gI = I; gJ = J; gK = K;
    num_i = IW'(I); num_j = IW'(J); num_k = IW'(K);
    start = 1'b1;
    mac_ready = (S == 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 400) begin
      if (inject && cyc == 5) begin
        start = 1'b1; num_i = 1; num_j = 1; num_k = 1;
      end else if (inject && cyc == 6) begin
        start = 1'b0; num_i = IW'(I); num_j = IW'(J); num_k = IW'(K);
      end
      if (eval_done) begin
        done_cyc = cyc;
        fin = 1;
      end else if (mac_valid) begin
        if (abort && ei == 1 && ej == 0 && ek == 2) begin
          reset = 1'b1;
          #1;
          chk("abort_busy", busy, 0);
          chk("abort_valid", mac_valid, 0);
          chk("abort_curr_i", curr_i, 0);
          chk("abort_curr_k", curr_k, 0);
          chk("abort_acc_last", acc_last, 0);
          chk("abort_addr_a", addr_a, 0);
          chk("abort_eval_done", eval_done, 0);
          fin = 1;
        end else begin
          chk("curr_i", curr_i, ei);
          chk("curr_j", curr_j, ej);
          chk("curr_k", curr_k, ek);
          chk("acc_clear", acc_clear, ek == 0);
          chk("acc_last", acc_last, ek == K - 1);
          chk("addr_a", addr_a, eaddr(ei, K, ek));
          chk("addr_b", addr_b, eaddr(ek, J, ej));
          chk("addr_c", addr_c, eaddr(ei, J, ej));
          chk("err_in_run", err_shape, 0);
          if (stall < S) begin
            mac_ready = 1'b0;
            stall++;
          end else begin
            mac_ready = 1'b1;
            stall = 0;
            issues++;
            ek++;
            if (ek == K) begin
              ek = 0; ej++;
              if (ej == J) begin ej = 0; ei++; end
            end
          end
        end
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!abort) begin
      chk("eval_cycle", 64'(done_cyc), 64'(I * J * K * (2 + S) + 1));
      chk("issue_count", 64'(issues), 64'(I * J * K));
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("eval_done_pulse", eval_done, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mac_ready = 1'b0;
    num_i = '0; num_j = '0; num_k = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", mac_valid, 0);
    chk("rst_eval", eval_done, 0);
    chk("rst_err", err_shape, 0);
    chk("rst_tuple", {curr_i, curr_j, curr_k}, 0);
    chk("rst_addr", {addr_a, addr_b}, 0);
    chk("rst_acc", {acc_clear, acc_last}, 0);
    reset = 1'b0;
    @(negedge clk);

    run(2, 2, 2, 0, 0, 0);
    run(1, 1, 1, 0, 0, 0);

    // Zero shape: straight to FINISH, sticky error, no issue
    num_i = 1; num_j = 0; num_k = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_eval", eval_done, 1);
    chk("zero_err", err_shape, 1);
    chk("zero_valid", mac_valid, 0);
    @(negedge clk);
    chk("zero_idle", busy, 0);
    chk("zero_err_sticky", err_shape, 1);
    chk("zero_no_valid", mac_valid, 0);
    run(1, 1, 1, 0, 0, 0);
    chk("err_cleared", err_shape, 0);

    run(2, 1, 3, 3, 0, 0);

    run(2, 1, 3, 0, 0, 1);
    @(negedge clk);
    chk("abort_hold_eval", eval_done, 0);
    chk("abort_hold_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_post_eval", eval_done, 0);
    run(2, 2, 2, 0, 0, 0);

    run(2, 2, 2, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

`default_nettype wire
